issue_ctrl: RTL and testbench

Instruction queue and in-order issue controller sitting between instruction fetch and the out-of-order backend. Buffers fetched instruction/PC pairs, presents the head instruction to the combinational RV32I decoder, and issues each decoded instruction to the reservation station (RS) or the load/store buffer (LSB) while a ROB entry is available. Handles backpressure, illegal-op discard and mispredict flush.

---
 rtl/issue_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_issue_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// issue_ctrl: instruction queue plus in-order issue controller.
//
// Buffers fetched {ins, pc} pairs in a circular queue, shows the head
// instruction to an external combinational decoder and issues the decoded
// fields to the RS or the LSB while a ROB entry is free. Illegal (WOW) heads
// are dropped with a one-cycle illegal_pulse.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global freeze), flush_in
//   if_valid/if_ins/if_pc    : fetch push
//   iq_full                  : queue holds depth entries
//   dec_ins -> dec_op/rd/rs1/rs2/imm : decoder round trip for the head
//   rob_full/rs_full/lsb_full: backend occupancy
//   issue_valid, issue_to_lsb, issue_op/rd/rs1/rs2/imm/pc : registered issue
//   illegal_pulse            : one cycle per discarded WOW op
//
// Optional build macro ISSUE_STALL_CNT_EN adds a saturating 32-bit stall_cnt
// output counting rdy_in-high cycles with a legal but blocked head.

// Op encoding shared with the decoder; only the values this block tests.
`ifndef OP_LEN
`define OP_LEN 6
`endif
`ifndef REG_LEN
`define REG_LEN 5
`endif
`ifndef IMM_LEN
`define IMM_LEN 32
`endif
`ifndef LB
`define LB 6'd11
`endif
`ifndef LHU
`define LHU 6'd15
`endif
`ifndef SB
`define SB 6'd16
`endif
`ifndef SD
`define SD 6'd19
`endif
`ifndef LD
`define LD 6'd20
`endif
`ifndef WOW
`define WOW 6'd63
`endif

module issue_ctrl #(
    parameter int unsigned IQ_DEPTH_LOG = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                if_valid,
    input  logic [31:0]         if_ins,
    input  logic [31:0]         if_pc,
    output logic                iq_full,
    output logic [31:0]         dec_ins,
    input  logic [`OP_LEN-1:0]  dec_op,
    input  logic [`REG_LEN-1:0] dec_rd,
    input  logic [`REG_LEN-1:0] dec_rs1,
    input  logic [`REG_LEN-1:0] dec_rs2,
    input  logic [`IMM_LEN-1:0] dec_imm,
    input  logic                rob_full,
    input  logic                rs_full,
    input  logic                lsb_full,
    output logic                issue_valid,
    output logic                issue_to_lsb,
    output logic [`OP_LEN-1:0]  issue_op,
    output logic [`REG_LEN-1:0] issue_rd,
    output logic [`REG_LEN-1:0] issue_rs1,
    output logic [`REG_LEN-1:0] issue_rs2,
    output logic [`IMM_LEN-1:0] issue_imm,
    output logic [31:0]         issue_pc,
    output logic                illegal_pulse
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int unsigned Depth = 1 << IQ_DEPTH_LOG;
    localparam logic [IQ_DEPTH_LOG:0] DepthCnt = Depth[IQ_DEPTH_LOG:0];

    typedef struct packed {
        logic                to_lsb;
        logic [`OP_LEN-1:0]  op;
        logic [`REG_LEN-1:0] rd;
        logic [`REG_LEN-1:0] rs1;
        logic [`REG_LEN-1:0] rs2;
        logic [`IMM_LEN-1:0] imm;
        logic [31:0]         pc;
    } issue_t;

    logic [31:0] ins_mem [Depth];
    logic [31:0] pc_mem  [Depth];

    logic [IQ_DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
    logic [IQ_DEPTH_LOG:0]   count_q, count_d;
    logic                    valid_q, valid_d, pulse_q, pulse_d;
    issue_t                  issue_q, issue_d;
    logic                    wr_en;

    logic empty, head_lsb, head_illegal, blocked, push, pop, issue_go;

    assign empty   = (count_q == '0);
    assign iq_full = (count_q == DepthCnt);
    assign dec_ins = empty ? 32'h0 : ins_mem[head_q];

    assign head_lsb     = (dec_op >= `LB && dec_op <= `LHU) || (dec_op == `LD) ||
                          (dec_op >= `SB && dec_op <= `SD);
    assign head_illegal = (dec_op == `WOW);
    assign blocked      = rob_full || (head_lsb ? lsb_full : rs_full);
    // Illegal heads leave regardless of backend occupancy.
    assign pop          = !empty && (head_illegal || !blocked);
    assign issue_go     = pop && !head_illegal;
    // Full check uses the current count, so a same-cycle pop does not free a slot.
    assign push         = if_valid && !iq_full;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        pulse_d = pulse_q;
        issue_d = issue_q;
        wr_en   = 1'b0;
        if (rdy_in) begin
            if (flush_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                valid_d = 1'b0;
                pulse_d = 1'b0;
            end else begin
                wr_en = push;
                if (push) tail_d = tail_q + 1'b1;
                if (pop)  head_d = head_q + 1'b1;
                unique case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
                valid_d = issue_go;
                pulse_d = pop && head_illegal;
                if (issue_go) begin
                    issue_d = '{to_lsb: head_lsb, op: dec_op, rd: dec_rd, rs1: dec_rs1,
                                rs2: dec_rs2, imm: dec_imm, pc: pc_mem[head_q]};
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            issue_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            issue_q <= issue_d;
            if (wr_en) begin
                ins_mem[tail_q] <= if_ins;
                pc_mem[tail_q]  <= if_pc;
            end
        end
    end

    assign issue_valid   = valid_q;
    assign illegal_pulse = pulse_q;
    assign issue_to_lsb  = issue_q.to_lsb;
    assign issue_op      = issue_q.op;
    assign issue_rd      = issue_q.rd;
    assign issue_rs1     = issue_q.rs1;
    assign issue_rs2     = issue_q.rs2;
    assign issue_imm     = issue_q.imm;
    assign issue_pc      = issue_q.pc;

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Counts regardless of flush: the head was still blocked that cycle.
    always_comb begin
        stall_d = stall_q;
        if (rdy_in && !empty && !head_illegal && blocked && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl. The bench also plays the decoder role,
// turning dec_ins into decoded fields. A queue-based reference model predicts
// every registered output and the queue-visible combinational outputs.
module tb_issue_ctrl;

    localparam logic [5:0] OP_LW   = 6'd13;
    localparam logic [5:0] OP_SW   = 6'd18;
    localparam logic [5:0] OP_ADDI = 6'd21;
    localparam logic [5:0] OP_ADD  = 6'd30;
    localparam logic [5:0] OP_WOW  = 6'd63;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        lsb;
        logic        ill;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_ins = '0, if_pc = '0;
    logic        rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
    logic        iq_full, issue_valid, issue_to_lsb, illegal_pulse;
    logic [31:0] dec_ins, issue_imm, issue_pc, dec_imm;
    logic [5:0]  dec_op, issue_op;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2, issue_rd, issue_rs1, issue_rs2;
    rec_t        dec_rec;
`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    issue_ctrl #(.IQ_DEPTH_LOG(3)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc), .iq_full(iq_full),
        .dec_ins(dec_ins), .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1),
        .dec_rs2(dec_rs2), .dec_imm(dec_imm), .rob_full(rob_full), .rs_full(rs_full),
        .lsb_full(lsb_full), .issue_valid(issue_valid), .issue_to_lsb(issue_to_lsb),
        .issue_op(issue_op), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .illegal_pulse(illegal_pulse)
`ifdef ISSUE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Decoder stand-in: ADDI, LW, SW, ADD; everything else is WOW.
    function automatic rec_t decode(input logic [31:0] ins);
        rec_t d;
        logic [31:0] i_imm, s_imm;
        d = '0;
        d.op = OP_WOW;
        i_imm = {{20{ins[31]}}, ins[31:20]};
        s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        case ({ins[14:12], ins[6:0]})
            {3'b000, 7'b0010011}: begin
                d.op = OP_ADDI; d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.imm = i_imm;
            end
            {3'b010, 7'b0000011}: begin
                d.op = OP_LW; d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.imm = i_imm;
            end
            {3'b010, 7'b0100011}: begin
                d.op = OP_SW; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.imm = s_imm;
            end
            {3'b000, 7'b0110011}: begin
                if (ins[31:25] == 7'b0) begin
                    d.op = OP_ADD; d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
                end
            end
            default: d.op = OP_WOW;
        endcase
        return d;
    endfunction

    assign dec_rec = decode(dec_ins);
    assign dec_op  = dec_rec.op;
    assign dec_rd  = dec_rec.rd;
    assign dec_rs1 = dec_rec.rs1;
    assign dec_rs2 = dec_rec.rs2;
    assign dec_imm = dec_rec.imm;

    // Builds an instruction from chosen fields and records what must issue.
    function automatic rec_t make_rec(input int kind, input logic [31:0] pc);
        rec_t r;
        logic [11:0] imm12;
        logic [4:0]  rd, rs1, rs2;
        imm12 = 12'($urandom);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        r = '0;
        r.pc = pc;
        case (kind)
            0: begin
                r.ins = {imm12, rs1, 3'b000, rd, 7'b0010011};
                r.op = OP_ADDI; r.rd = rd; r.rs1 = rs1; r.imm = {{20{imm12[11]}}, imm12};
            end
            1: begin
                r.ins = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
                r.op = OP_ADD; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
            end
            2: begin
                r.ins = {imm12, rs1, 3'b010, rd, 7'b0000011};
                r.op = OP_LW; r.rd = rd; r.rs1 = rs1; r.imm = {{20{imm12[11]}}, imm12};
                r.lsb = 1'b1;
            end
            3: begin
                r.ins = {imm12[11:5], rs2, rs1, 3'b010, imm12[4:0], 7'b0100011};
                r.op = OP_SW; r.rs1 = rs1; r.rs2 = rs2; r.imm = {{20{imm12[11]}}, imm12};
                r.lsb = 1'b1;
            end
            default: begin
                r.ins = 32'hFFFF_FFFF; r.op = OP_WOW; r.ill = 1'b1;
            end
        endcase
        return r;
    endfunction

    // Reference model state.
    rec_t        mq[$];
    rec_t        pend;
    logic        m_valid = 0, m_pulse = 0;
    rec_t        m_pay = '0;
    int          n_checks = 0, n_fail = 0, n_issued = 0, n_pulses = 0;
    logic [31:0] pc_next = 32'h100;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_edge();
        rec_t h;
        bit   was_full;
        if (rst_in) begin
            mq.delete(); m_valid = 0; m_pulse = 0; m_pay = '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                mq.delete(); m_valid = 0; m_pulse = 0;
            end else begin
                was_full = (mq.size() == 8);
                m_valid = 0; m_pulse = 0;
                if (mq.size() > 0) begin
                    h = mq[0];
                    if (h.ill) begin
                        mq.delete(0); m_pulse = 1;
                    end else if (!rob_full && !(h.lsb ? lsb_full : rs_full)) begin
                        mq.delete(0); m_valid = 1; m_pay = h;
                    end
                end
                if (if_valid && !was_full) mq.push_back(pend);
            end
        end
    endtask

    task automatic compare_all();
        check("issue_valid", 64'(issue_valid), 64'(m_valid));
        check("illegal_pulse", 64'(illegal_pulse), 64'(m_pulse));
        check("iq_full", 64'(iq_full), 64'(mq.size() == 8));
        check("dec_ins", 64'(dec_ins), 64'(mq.size() > 0 ? mq[0].ins : 32'h0));
        check("issue_to_lsb", 64'(issue_to_lsb), 64'(m_pay.lsb));
        check("issue_op", 64'(issue_op), 64'(m_pay.op));
        check("issue_rd", 64'(issue_rd), 64'(m_pay.rd));
        check("issue_rs1", 64'(issue_rs1), 64'(m_pay.rs1));
        check("issue_rs2", 64'(issue_rs2), 64'(m_pay.rs2));
        check("issue_imm", 64'(issue_imm), 64'(m_pay.imm));
        check("issue_pc", 64'(issue_pc), 64'(m_pay.pc));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (issue_valid && rdy_in) n_issued++;
        if (illegal_pulse && rdy_in) n_pulses++;
        compare_all();
    endtask

    task automatic drive_push(input rec_t r);
        if_valid = 1'b1; if_ins = r.ins; if_pc = r.pc; pend = r;
    endtask

    task automatic drive_idle();
        if_valid = 1'b0; if_ins = 32'h0; if_pc = 32'h0;
    endtask

    task automatic push_kind(input int kind);
        drive_push(make_rec(kind, pc_next));
        pc_next += 4;
    endtask

    initial begin
        rec_t r;
        int   base;

        // Reset.
        drive_idle();
        step(); step();
        rst_in = 1'b0;
        step();
        check("rst_dec_ins", 64'(dec_ins), 64'h0);
        check("rst_valid", 64'(issue_valid), 64'h0);

        // ADDI x1,x0,5 at pc 0: issues after the second edge.
        r = '0;
        r.ins = 32'h0050_0093; r.op = OP_ADDI; r.rd = 5'd1; r.imm = 32'd5;
        drive_push(r);
        step();
        check("addi_not_yet", 64'(issue_valid), 64'h0);
        drive_idle();
        step();
        check("addi_valid", 64'(issue_valid), 64'h1);
        check("addi_op", 64'(issue_op), 64'(OP_ADDI));
        check("addi_rd", 64'(issue_rd), 64'h1);
        check("addi_imm", 64'(issue_imm), 64'h5);
        check("addi_lsb", 64'(issue_to_lsb), 64'h0);
        check("addi_pc", 64'(issue_pc), 64'h0);

        // Fill to full under rs_full, ninth push dropped, then drain 8.
        rs_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_kind(i % 2);
            step();
        end
        check("fill_full", 64'(iq_full), 64'h1);
        push_kind(0);
        step();
        drive_idle();
        rs_full = 1'b0;
        base = n_issued;
        for (int i = 0; i < 12; i++) step();
        check("drain_count", 64'(n_issued - base), 64'd8);

        // LW blocked by lsb_full only.
        lsb_full = 1'b1;
        r = make_rec(2, 32'h200);
        r.ins = {12'd4, 5'd1, 3'b010, 5'd2, 7'b0000011};
        r.rd = 5'd2; r.rs1 = 5'd1; r.imm = 32'd4;
        drive_push(r);
        step();
        drive_idle();
        step(); step();
        check("lw_blocked", 64'(issue_valid), 64'h0);
        lsb_full = 1'b0;
        step();
        check("lw_valid", 64'(issue_valid), 64'h1);
        check("lw_lsb", 64'(issue_to_lsb), 64'h1);
        check("lw_op", 64'(issue_op), 64'(OP_LW));

        // WOW followed by a legal op; WOW ignores full flags.
        rob_full = 1'b1;
        base = n_pulses;
        push_kind(4);
        step();
        push_kind(0);
        step();
        drive_idle();
        step();
        rob_full = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("wow_pulses", 64'(n_pulses - base), 64'd1);

        // Flush with a same-cycle push.
        rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_kind(i);
            step();
        end
        flush_in = 1'b1;
        push_kind(1);
        step();
        flush_in = 1'b0;
        drive_idle();
        check("flush_empty", 64'(dec_ins), 64'h0);
        rob_full = 1'b0;
        base = n_issued;
        for (int i = 0; i < 3; i++) step();
        check("flush_no_issue", 64'(n_issued - base), 64'd0);

        // rdy_in low for 5 cycles mid-stream.
        for (int i = 0; i < 4; i++) begin
            push_kind(i % 4);
            step();
        end
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_kind(0);
            step();
        end
        rdy_in = 1'b1;
        drive_idle();
        for (int i = 0; i < 8; i++) step();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 60) push_kind(int'($urandom_range(4)));
            else drive_idle();
            rob_full = ($urandom_range(99) < 20);
            rs_full  = ($urandom_range(99) < 25);
            lsb_full = ($urandom_range(99) < 25);
            flush_in = ($urandom_range(99) < 3);
            rdy_in   = ($urandom_range(99) >= 10);
            rst_in   = ($urandom_range(999) < 5);
            step();
        end
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        drive_idle();
        for (int i = 0; i < 10; i++) step();
        check("final_empty", 64'(dec_ins), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
